// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcodes, ALU operation codes, operand selects and
// immediate formats used by decode, the ALU and the EX stage.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    A_RS1,
    A_PC,
    A_ZERO
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2,
    B_IMM,
    B_FOUR
  } b_sel_e;

  // alt selects sub (funct3 000) or sra (funct3 101); ignored for other funct3.
  function automatic alu_op_e alu_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended RV32I immediates for every instruction format.
module imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/decode_stage.sv
// RV32I decode with operand forwarding, load-use hazard detection and the
// ID/EX pipeline register, valid/ready on both sides.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic            ex_fwd_we,
  input  logic [4:0]      ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            ex_is_load,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] data_A,
  output logic [XLEN-1:0] data_B,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal,
  output logic [XLEN-1:0] br_target
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_d;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_val, a_d, b_d, tgt_d;
  alu_op_e         op_d;
  a_sel_e          a_sel;
  b_sel_e          b_sel;
  imm_fmt_e        fmt;
  logic            rw_d, mr_d, mw_d, br_d, jp_d, ill_d;
  logic            use1, use2;
  logic            adv, hazard, accept;

  assign opcode   = in_instr[6:0];
  assign rd_d     = in_instr[11:7];
  assign f3       = in_instr[14:12];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign f7       = in_instr[31:25];

  imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // EX bypass is applied last so it overrides the older WB value.
  always_comb begin
    rs1_val = rs1_rdata;
    rs2_val = rs2_rdata;
    if (FWD_EN) begin
      if (wb_we && wb_rd == rs1_addr)         rs1_val = wb_data;
      if (wb_we && wb_rd == rs2_addr)         rs2_val = wb_data;
      if (ex_fwd_we && ex_fwd_rd == rs1_addr) rs1_val = ex_fwd_data;
      if (ex_fwd_we && ex_fwd_rd == rs2_addr) rs2_val = ex_fwd_data;
    end
    if (rs1_addr == '0) rs1_val = '0;
    if (rs2_addr == '0) rs2_val = '0;
  end

  always_comb begin
    op_d  = ALU_ADD;
    a_sel = A_RS1;
    b_sel = B_RS2;
    fmt   = IMM_I;
    rw_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    br_d  = 1'b0;
    jp_d  = 1'b0;
    ill_d = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    tgt_d = '0;
    case (opcode)
      OPC_LUI: begin
        a_sel = A_ZERO; b_sel = B_IMM; fmt = IMM_U; rw_d = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel = A_PC; b_sel = B_IMM; fmt = IMM_U; rw_d = 1'b1;
      end
      OPC_JAL: begin
        a_sel = A_PC; b_sel = B_FOUR; rw_d = 1'b1; jp_d = 1'b1;
        tgt_d = in_pc + imm_j;
      end
      OPC_JALR: begin
        a_sel = A_PC; b_sel = B_FOUR; rw_d = 1'b1; jp_d = 1'b1; use1 = 1'b1;
        tgt_d = (rs1_val + imm_i) & ~XLEN'(1);
      end
      OPC_OP_IMM: begin
        b_sel = B_IMM; rw_d = 1'b1; use1 = 1'b1;
        op_d  = alu_op(f3, (f3 == 3'b101) && in_instr[30]);
      end
      OPC_OP: begin
        rw_d = 1'b1; use1 = 1'b1; use2 = 1'b1;
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
          op_d = alu_op(f3, f7[5]);
        else
          ill_d = 1'b1;
      end
      OPC_LOAD: begin
        b_sel = B_IMM; rw_d = 1'b1; mr_d = 1'b1; use1 = 1'b1;
      end
      OPC_STORE: begin
        b_sel = B_IMM; fmt = IMM_S; mw_d = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      OPC_BRANCH: begin
        br_d = 1'b1; use1 = 1'b1; use2 = 1'b1;
        tgt_d = in_pc + imm_b;
        case (f3[2:1])
          2'b10:   op_d = ALU_SLT;
          2'b11:   op_d = ALU_SLTU;
          default: op_d = ALU_SUB;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      op_d = ALU_ADD;
      rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; br_d = 1'b0; jp_d = 1'b0;
    end
    if (rd_d == '0) rw_d = 1'b0;
  end

  always_comb begin
    case (fmt)
      IMM_S:   imm_val = imm_s;
      IMM_B:   imm_val = imm_b;
      IMM_U:   imm_val = imm_u;
      IMM_J:   imm_val = imm_j;
      default: imm_val = imm_i;
    endcase
    case (a_sel)
      A_PC:    a_d = in_pc;
      A_ZERO:  a_d = '0;
      default: a_d = rs1_val;
    endcase
    case (b_sel)
      B_IMM:   b_d = imm_val;
      B_FOUR:  b_d = XLEN'(4);
      default: b_d = rs2_val;
    endcase
  end

  assign adv    = out_ready || !out_valid;
  assign hazard = ex_is_load && (ex_fwd_rd != '0) &&
                  ((use1 && ex_fwd_rd == rs1_addr) || (use2 && ex_fwd_rd == rs2_addr));
  assign in_ready = adv && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_ctrl   <= '0;
      data_A     <= '0;
      data_B     <= '0;
      store_data <= '0;
      rd         <= '0;
      funct3     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      illegal    <= 1'b0;
      br_target  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid  <= accept;
      alu_ctrl   <= op_d;
      data_A     <= a_d;
      data_B     <= b_d;
      store_data <= rs2_val;
      rd         <= rd_d;
      funct3     <= f3;
      reg_write  <= rw_d;
      mem_read   <= mr_d;
      mem_write  <= mw_d;
      branch     <= br_d;
      jump       <= jp_d;
      illegal    <= ill_d;
      br_target  <= tgt_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode table plus hazard, stall,
// flush and reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ex_fwd_we, ex_is_load, wb_we, flush;
  logic        out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_rdata, rs2_rdata, ex_fwd_data, wb_data;
  logic [4:0]  rs1_addr, rs2_addr, ex_fwd_rd, wb_rd, rd;
  logic [3:0]  alu_ctrl;
  logic [31:0] data_A, data_B, store_data, br_target;
  logic [2:0]  funct3;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .ex_fwd_we(ex_fwd_we),
    .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .data_A(data_A), .data_B(data_B), .store_data(store_data), .rd(rd),
    .funct3(funct3), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal),
    .br_target(br_target)
  );

  typedef struct {
    logic [31:0] instr, pc, rs1d, rs2d;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_d;
    logic        wb_w;
    logic [4:0]  wb_r;
    logic [31:0] wb_d;
    logic [3:0]  alu;
    logic [31:0] a, b;
    logic [4:0]  rdx;
    logic [5:0]  flags;    // {reg_write, mem_read, mem_write, branch, jump, illegal}
    logic        chk_ab;
    logic        chk_tgt;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({tag, " data_A"}, data_A, 32'd0);
    chk({tag, " data_B"}, data_B, 32'd0);
    chk({tag, " store_data"}, store_data, 32'd0);
    chk({tag, " rd/funct3"}, {24'd0, rd, funct3}, 32'd0);
    chk({tag, " ctrl bits"}, 32'({reg_write, mem_read, mem_write, branch, jump, illegal}), 32'd0);
    chk({tag, " br_target"}, br_target, 32'd0);
  endtask

  task automatic clear_bypass();
    ex_fwd_we = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0; ex_is_load = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  initial begin
    //          instr         pc         rs1d          rs2d        ex we rd data        wb we rd data     alu a             b             rd  flags     ab tgtchk tgt
    vecs[0]  = '{32'h00500093, 32'h100,  32'hDEAD,     32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h0,        32'h5,        1,  6'b100000, 1, 0, 0};
    vecs[1]  = '{32'h00500093, 32'h100,  32'hDEAD,     32'h22,     1, 0, 32'h999,      0, 0, 0,          0, 32'h0,        32'h5,        1,  6'b100000, 1, 0, 0};
    vecs[2]  = '{32'h402081B3, 32'h100,  32'd7,        32'd3,      0, 0, 0,            0, 0, 0,          1, 32'd7,        32'd3,        3,  6'b100000, 1, 0, 0};
    vecs[3]  = '{32'h402081B3, 32'h100,  32'd7,        32'd3,      1, 1, 32'd100,      1, 1, 32'd50,     1, 32'd100,      32'd3,        3,  6'b100000, 1, 0, 0};
    vecs[4]  = '{32'h402081B3, 32'h100,  32'd7,        32'd3,      0, 0, 0,            1, 1, 32'd50,     1, 32'd50,       32'd3,        3,  6'b100000, 1, 0, 0};
    vecs[5]  = '{32'h402081B3, 32'h100,  32'd7,        32'd3,      1, 1, 32'd100,      1, 2, 32'd77,     1, 32'd100,      32'd77,       3,  6'b100000, 1, 0, 0};
    vecs[6]  = '{32'h40435293, 32'h100,  32'h80,       32'h22,     0, 0, 0,            0, 0, 0,          9, 32'h80,       32'h404,      5,  6'b100000, 1, 0, 0};
    vecs[7]  = '{32'h00000FFF, 32'h100,  32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h0,        32'h0,        31, 6'b000001, 0, 0, 0};
    vecs[8]  = '{32'h123453B7, 32'h100,  32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h0,        32'h12345000, 7,  6'b100000, 1, 0, 0};
    vecs[9]  = '{32'hFFFFF417, 32'h1000, 32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h1000,     32'hFFFFF000, 8,  6'b100000, 1, 0, 0};
    vecs[10] = '{32'h008000EF, 32'h100,  32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h100,      32'h4,        1,  6'b100010, 1, 1, 32'h108};
    vecs[11] = '{32'h00308167, 32'h200,  32'h2000,     32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h200,      32'h4,        2,  6'b100010, 1, 1, 32'h2002};
    vecs[12] = '{32'hFE208EE3, 32'h400,  32'd5,        32'd6,      0, 0, 0,            0, 0, 0,          1, 32'd5,        32'd6,        29, 6'b000100, 1, 1, 32'h3FC};
    vecs[13] = '{32'hFE20EEE3, 32'h400,  32'd5,        32'd6,      0, 0, 0,            0, 0, 0,          6, 32'd5,        32'd6,        29, 6'b000100, 1, 1, 32'h3FC};
    vecs[14] = '{32'hFF832283, 32'h100,  32'h1000,     32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h1000,     32'hFFFFFFF8, 5,  6'b110000, 1, 0, 0};
    vecs[15] = '{32'h00732623, 32'h100,  32'h1000,     32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h1000,     32'd12,       12, 6'b001000, 1, 0, 0};
    vecs[16] = '{32'h02208133, 32'h100,  32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h0,        32'h0,        2,  6'b000001, 0, 0, 0};
    vecs[17] = '{32'hFFF0B213, 32'h100,  32'd1,        32'h22,     0, 0, 0,            0, 0, 0,          6, 32'd1,        32'hFFFFFFFF, 4,  6'b100000, 1, 0, 0};
    vecs[18] = '{32'h40008093, 32'h100,  32'd1,        32'h22,     0, 0, 0,            0, 0, 0,          0, 32'd1,        32'h400,      1,  6'b100000, 1, 0, 0};
    vecs[19] = '{32'h0020C4B3, 32'h100,  32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          4, 32'h11,       32'h22,       9,  6'b100000, 1, 0, 0};
    vecs[20] = '{32'h4020D533, 32'h100,  32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          9, 32'h11,       32'h22,       10, 6'b100000, 1, 0, 0};
    vecs[21] = '{32'h00208033, 32'h100,  32'h11,       32'h22,     0, 0, 0,            0, 0, 0,          0, 32'h11,       32'h22,       0,  6'b000000, 1, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; rs1_rdata = '0; rs2_rdata = '0;
    flush = 1'b0; out_ready = 1'b1;
    clear_bypass();
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      in_instr = v.instr; in_pc = v.pc; rs1_rdata = v.rs1d; rs2_rdata = v.rs2d;
      ex_fwd_we = v.ex_we; ex_fwd_rd = v.ex_rd; ex_fwd_data = v.ex_d; ex_is_load = 1'b0;
      wb_we = v.wb_w; wb_rd = v.wb_r; wb_data = v.wb_d;
      in_valid = 1'b1;
      step();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(v.alu));
      chk($sformatf("v%0d rd", i), 32'(rd), 32'(v.rdx));
      chk($sformatf("v%0d funct3", i), 32'(funct3), 32'(v.instr[14:12]));
      chk($sformatf("v%0d ctrl bits", i),
          32'({reg_write, mem_read, mem_write, branch, jump, illegal}), 32'(v.flags));
      if (v.chk_ab) begin
        chk($sformatf("v%0d data_A", i), data_A, v.a);
        chk($sformatf("v%0d data_B", i), data_B, v.b);
      end
      if (v.chk_tgt) chk($sformatf("v%0d br_target", i), br_target, v.tgt);
    end

    // load-use hazard on rs2 inserts one bubble, then forwards
    clear_bypass();
    in_instr = 32'h402081B3; rs1_rdata = 32'd7; rs2_rdata = 32'd3; in_valid = 1'b1;
    ex_is_load = 1'b1; ex_fwd_we = 1'b1; ex_fwd_rd = 5'd2; ex_fwd_data = 32'h55;
    #1;
    chk("hazard in_ready", 32'(in_ready), 32'd0);
    step();
    chk("hazard bubble", 32'(out_valid), 32'd0);
    ex_is_load = 1'b0;
    #1;
    chk("post-hazard in_ready", 32'(in_ready), 32'd1);
    step();
    chk("post-hazard out_valid", 32'(out_valid), 32'd1);
    chk("post-hazard data_B", data_B, 32'h55);
    chk("post-hazard data_A", data_A, 32'd7);

    // no hazard when the matching register is unused or x0
    in_instr = 32'h00500093; ex_is_load = 1'b1; ex_fwd_rd = 5'd5;
    #1;
    chk("unused rs2 no hazard", 32'(in_ready), 32'd1);
    ex_fwd_rd = 5'd0;
    #1;
    chk("x0 no hazard", 32'(in_ready), 32'd1);
    clear_bypass();

    // store data follows the forward priority
    in_instr = 32'h00732623; rs1_rdata = 32'h1000; rs2_rdata = 32'h1111;
    ex_fwd_we = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 32'hCAFE;
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hBEEF;
    step();
    chk("store_data ex fwd", store_data, 32'hCAFE);
    ex_fwd_we = 1'b0;
    step();
    chk("store_data wb fwd", store_data, 32'hBEEF);
    clear_bypass();
    step();
    chk("store_data regfile", store_data, 32'h1111);

    // back-pressure: outputs hold for three cycles
    in_instr = 32'h00500093;
    step();
    chk("stall setup valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    in_instr = 32'h0020C4B3; rs1_rdata = 32'h11; rs2_rdata = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d alu_ctrl", i), 32'(alu_ctrl), 32'd0);
      chk($sformatf("stall%0d data_B", i), data_B, 32'd5);
      chk($sformatf("stall%0d rd", i), 32'(rd), 32'd1);
    end
    flush = 1'b1;
    step();
    chk("flush in stall", 32'(out_valid), 32'd0);

    // flush drops the instruction presented in the same cycle
    out_ready = 1'b1;
    #1;
    chk("flush in_ready", 32'(in_ready), 32'd0);
    step();
    chk("flush drops instr", 32'(out_valid), 32'd0);
    flush = 1'b0;
    step();
    chk("after flush valid", 32'(out_valid), 32'd1);
    chk("after flush alu_ctrl", 32'(alu_ctrl), 32'd4);

    rst = 1'b1;
    step();
    chk_zero("mid rst");
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("idle after rst", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
